// File: rtl/pico_stream_out_mc.sv
// rtl/pico_stream_out_mc.sv - multi-channel packing stream output engine with descriptor queues
// Per-channel packer, data FIFO and descriptor FIFO behind one shared bus read/write/poll port.
module pico_stream_out_mc #(
  parameter int ID_BASE      = 1,
  parameter int NUM_CH       = 4,
  parameter int USER_W       = 32,
  parameter int DATA_DEPTH   = 512,
  parameter int DESC_DEPTH   = 32,
  parameter int AFULL_MARGIN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        s_valid,
  input  logic [NUM_CH*USER_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_last,
  output logic [NUM_CH-1:0]        s_rdy,
  input  logic                     s_out_en,
  input  logic [8:0]               s_out_id,
  output logic [127:0]             s_out_data,
  input  logic                     s_in_valid,
  input  logic [8:0]               s_in_id,
  input  logic [127:0]             s_in_data,
  input  logic [8:0]               s_poll_id,
  output logic [31:0]              s_poll_seq,
  output logic [127:0]             s_poll_next_desc,
  output logic                     s_poll_next_desc_valid,
  input  logic [8:0]               s_next_desc_rd_id,
  input  logic                     s_next_desc_rd_en,
  output logic [2:0]               err_flags
);
  localparam int PACK   = 128 / USER_W;
  localparam int PW     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int DAW    = $clog2(DATA_DEPTH);
  localparam int QAW    = $clog2(DESC_DEPTH);
  localparam int THRESH = DATA_DEPTH - AFULL_MARGIN;

  logic              r_init;
  logic [127:0]      w_rd_word   [NUM_CH];
  logic [31:0]       w_poll_seq  [NUM_CH];
  logic [127:0]      w_poll_desc [NUM_CH];
  logic [NUM_CH-1:0] w_poll_vld, w_rd_under, w_push_drop, w_pop_under;
  logic [127:0]      w_out_data, w_pdesc;
  logic [31:0]       w_pseq;
  logic              w_pvld;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [8:0] DID = {2'b00, 7'(ID_BASE + c)};
    localparam logic [8:0] QID = {2'b10, 7'(ID_BASE + c)};

    logic [127:0]      r_dmem [DATA_DEPTH];
    logic [127:0]      r_qmem [DESC_DEPTH];
    logic [DAW:0]      r_wp, r_rp;
    logic [QAW:0]      r_qwp, r_qrp;
    logic [127:0]      r_pack, r_cw;
    logic [PW-1:0]     r_cnt;
    logic              r_cv, r_rdy;
    logic [31:0]       r_dseq, r_qseq;
    logic [USER_W-1:0] w_beat;
    logic [127:0]      w_cword;
    logic [DAW:0]      w_dcnt;
    logic [DAW+1:0]    w_occ;
    logic [QAW:0]      w_qcnt;
    logic w_acc, w_cmt, w_dempty, w_drd, w_dpop, w_qempty, w_qfull;
    logic w_qpush_req, w_qpop_req, w_qpush, w_qpop, w_pd, w_pq;

    assign w_beat  = s_data[c*USER_W +: USER_W];
    assign w_acc   = s_valid[c] & r_rdy;
    assign w_cmt   = w_acc & (s_last[c] | (r_cnt == PW'(PACK - 1)));
    assign w_cword = r_pack | (128'(w_beat) << (32'(r_cnt) * USER_W));

    assign w_dcnt   = r_wp - r_rp;
    assign w_dempty = (r_wp == r_rp);
    assign w_drd    = s_out_en && (s_out_id == DID);
    assign w_dpop   = w_drd && !w_dempty;
    // The commit register holds a word that lands in the FIFO next edge, so count it too.
    assign w_occ    = {1'b0, w_dcnt} + {{(DAW+1){1'b0}}, r_cv};

    assign w_qcnt      = r_qwp - r_qrp;
    assign w_qempty    = (r_qwp == r_qrp);
    assign w_qfull     = (w_qcnt == (QAW+1)'(DESC_DEPTH));
    assign w_qpop_req  = s_next_desc_rd_en && (s_next_desc_rd_id == DID);
    assign w_qpush_req = s_in_valid && (s_in_id == QID);
    assign w_qpop      = w_qpop_req && !w_qempty;
    assign w_qpush     = w_qpush_req && (!w_qfull || w_qpop);
    assign w_pd        = (s_poll_id == DID);
    assign w_pq        = (s_poll_id == QID);

    assign s_rdy[c]       = r_rdy;
    assign w_rd_word[c]   = w_dpop ? r_dmem[r_rp[DAW-1:0]] : '0;
    assign w_rd_under[c]  = w_drd && w_dempty;
    assign w_push_drop[c] = w_qpush_req && !w_qpush;
    assign w_pop_under[c] = w_qpop_req && w_qempty;
    assign w_poll_seq[c]  = w_pd ? r_dseq : (w_pq ? r_qseq : '0);
    assign w_poll_vld[c]  = w_pd && !w_qempty;
    assign w_poll_desc[c] = (w_pd && !w_qempty) ? r_qmem[r_qrp[QAW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_qwp  <= '0;
        r_qrp  <= '0;
        r_pack <= '0;
        r_cw   <= '0;
        r_cnt  <= '0;
        r_cv   <= 1'b0;
        r_rdy  <= 1'b0;
        r_dseq <= '0;
        r_qseq <= 32'h200;
      end else begin
        r_rdy <= r_init && (w_occ < (DAW+2)'(THRESH));
        r_cv  <= w_cmt;
        if (w_cmt) begin
          r_cw   <= w_cword;
          r_pack <= '0;
          r_cnt  <= '0;
        end else if (w_acc) begin
          r_pack <= w_cword;
          r_cnt  <= r_cnt + PW'(1);
        end
        if (r_cv) begin
          r_wp   <= r_wp + (DAW+1)'(1);
          r_dseq <= r_dseq + 32'd16;
        end
        if (w_dpop)  r_rp  <= r_rp + (DAW+1)'(1);
        if (w_qpush) r_qwp <= r_qwp + (QAW+1)'(1);
        if (w_qpop) begin
          r_qrp  <= r_qrp + (QAW+1)'(1);
          r_qseq <= r_qseq + 32'd16;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (r_cv)    r_dmem[r_wp[DAW-1:0]]   <= r_cw;
      if (w_qpush) r_qmem[r_qwp[QAW-1:0]] <= s_in_data;
    end
  end

  // At most one channel matches any id, so OR-combining the gated per-channel terms is a mux.
  always_comb begin
    w_out_data = '0;
    w_pseq     = '0;
    w_pdesc    = '0;
    w_pvld     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_out_data = w_out_data | w_rd_word[c];
      w_pseq     = w_pseq | w_poll_seq[c];
      w_pdesc    = w_pdesc | w_poll_desc[c];
      w_pvld     = w_pvld | w_poll_vld[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init                 <= 1'b0;
      s_out_data             <= '0;
      s_poll_seq             <= '0;
      s_poll_next_desc       <= '0;
      s_poll_next_desc_valid <= 1'b0;
      err_flags              <= '0;
    end else begin
      r_init                 <= 1'b1;
      s_out_data             <= w_out_data;
      s_poll_seq             <= w_pseq;
      s_poll_next_desc       <= w_pdesc;
      s_poll_next_desc_valid <= w_pvld;
      err_flags              <= err_flags | {|w_pop_under, |w_push_drop, |w_rd_under};
    end
  end
endmodule

// File: tb/tb_pico_stream_out_mc.sv
// tb/tb_pico_stream_out_mc.sv - randomized and directed bench for pico_stream_out_mc
// Queue-based reference model, checked every cycle, plus literal expectations.
module tb_pico_stream_out_mc;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] s_valid, s_last, s_rdy;
  logic [127:0]   s_data;
  logic           s_out_en, s_in_valid, s_next_desc_rd_en, s_poll_next_desc_valid;
  logic [8:0]     s_out_id, s_in_id, s_poll_id, s_next_desc_rd_id;
  logic [127:0]   s_out_data, s_in_data, s_poll_next_desc;
  logic [31:0]    s_poll_seq;
  logic [2:0]     err_flags;

  always #5 clk = ~clk;

  pico_stream_out_mc dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_rdy(s_rdy),
    .s_out_en(s_out_en), .s_out_id(s_out_id), .s_out_data(s_out_data),
    .s_in_valid(s_in_valid), .s_in_id(s_in_id), .s_in_data(s_in_data),
    .s_poll_id(s_poll_id), .s_poll_seq(s_poll_seq), .s_poll_next_desc(s_poll_next_desc),
    .s_poll_next_desc_valid(s_poll_next_desc_valid),
    .s_next_desc_rd_id(s_next_desc_rd_id), .s_next_desc_rd_en(s_next_desc_rd_en),
    .err_flags(err_flags)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: what each FIFO holds, beats waiting to form a word, counters, sticky errors.
  logic [127:0] m_fifo  [NCH][$];
  logic [127:0] m_desc  [NCH][$];
  logic [31:0]  m_beats [NCH][$];
  bit           m_pend_v [NCH];
  logic [127:0] m_pend_w [NCH];
  logic [31:0]  m_dseq [NCH];
  logic [31:0]  m_qseq [NCH];
  logic [2:0]   m_err;
  int           m_edges;
  logic [127:0] e_out, e_pdesc;
  logic [31:0]  e_pseq;
  logic         e_pvld;

  function automatic int dch(input logic [8:0] id, input logic [1:0] pre);
    int n;
    n = int'(id[6:0]) - 1;
    if (id[8:7] != pre || n < 0 || n >= NCH) return -1;
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_fifo[c].delete();
      m_desc[c].delete();
      m_beats[c].delete();
      m_pend_v[c] = 1'b0;
      m_pend_w[c] = '0;
      m_dseq[c]   = 32'h0;
      m_qseq[c]   = 32'h200;
    end
    m_err = 3'b000;
    m_edges = 0;
    e_out = '0; e_pdesc = '0; e_pseq = '0; e_pvld = 1'b0;
  endtask

  // One step = the effect of the coming rising edge, using the inputs presented now.
  task automatic model_step();
    int pc, qc, rc, pp;
    logic [127:0] w;
    pc = dch(s_poll_id, 2'b00);
    qc = dch(s_poll_id, 2'b10);
    e_pseq = '0; e_pdesc = '0; e_pvld = 1'b0;
    if (pc >= 0) begin
      e_pseq = m_dseq[pc];
      if (m_desc[pc].size() > 0) begin
        e_pvld  = 1'b1;
        e_pdesc = m_desc[pc][0];
      end
    end else if (qc >= 0) begin
      e_pseq = m_qseq[qc];
    end
    e_out = '0;
    rc = s_out_en ? dch(s_out_id, 2'b00) : -1;
    if (rc >= 0) begin
      if (m_fifo[rc].size() > 0) e_out = m_fifo[rc].pop_front();
      else m_err[0] = 1'b1;
    end
    pp = s_next_desc_rd_en ? dch(s_next_desc_rd_id, 2'b00) : -1;
    qc = s_in_valid ? dch(s_in_id, 2'b10) : -1;
    if (pp >= 0) begin
      if (m_desc[pp].size() > 0) begin
        void'(m_desc[pp].pop_front());
        m_qseq[pp] += 32'd16;
      end else m_err[2] = 1'b1;
    end
    if (qc >= 0) begin
      if (m_desc[qc].size() < 32) m_desc[qc].push_back(s_in_data);
      else m_err[1] = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (m_pend_v[c]) begin
        m_fifo[c].push_back(m_pend_w[c]);
        m_dseq[c] += 32'd16;
        m_pend_v[c] = 1'b0;
      end
      if (s_valid[c] && s_rdy[c]) begin
        m_beats[c].push_back(s_data[c*32 +: 32]);
        if (m_beats[c].size() == 4 || s_last[c]) begin
          w = '0;
          for (int k = 0; k < m_beats[c].size(); k++) w[k*32 +: 32] = m_beats[c][k];
          m_pend_v[c] = 1'b1;
          m_pend_w[c] = w;
          m_beats[c].delete();
        end
      end
    end
    m_edges++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_data", s_out_data, '0);
      chk("rst_poll_seq", 128'(s_poll_seq), '0);
      chk("rst_poll_desc", s_poll_next_desc, '0);
      chk("rst_poll_vld", 128'(s_poll_next_desc_valid), '0);
      chk("rst_rdy", 128'(s_rdy), '0);
      chk("rst_err", 128'(err_flags), '0);
      model_reset();
    end else begin
      chk("out_data", s_out_data, e_out);
      chk("poll_seq", 128'(s_poll_seq), 128'(e_pseq));
      chk("poll_desc", s_poll_next_desc, e_pdesc);
      chk("poll_vld", 128'(s_poll_next_desc_valid), 128'(e_pvld));
      chk("err_flags", 128'(err_flags), 128'(m_err));
      for (int c = 0; c < NCH; c++) begin
        if (m_edges < 2) chk("rdy_init", 128'(s_rdy[c]), 128'(0));
        else if (m_fifo[c].size() + int'(m_pend_v[c]) < 500) chk("rdy_low_occ", 128'(s_rdy[c]), 128'(1));
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = '0; s_last = '0; s_out_en = 1'b0; s_in_valid = 1'b0; s_next_desc_rd_en = 1'b0;
  endtask

  task automatic send_beat(input int c, input logic [31:0] d, input logic l);
    int t;
    t = 0;
    while (!s_rdy[c] && t < 100) begin
      tick();
      t++;
    end
    if (!s_rdy[c]) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat_timeout ch=%0d actual_rdy=0 required_rdy=1", c);
    end
    s_valid[c] = 1'b1; s_data[c*32 +: 32] = d; s_last[c] = l;
    tick();
    s_valid[c] = 1'b0; s_last[c] = 1'b0;
  endtask

  task automatic rd(input logic [8:0] id);
    s_out_en = 1'b1; s_out_id = id;
    tick();
    s_out_en = 1'b0;
  endtask

  task automatic poll(input logic [8:0] id);
    s_poll_id = id;
    tick();
  endtask

  logic [8:0]   ids [8] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h101, 9'h103};
  logic [127:0] first_desc;
  logic [127:0] d0, d1;
  int           cyc;

  initial begin
    idle();
    s_data = '0; s_out_id = '0; s_in_id = '0; s_in_data = '0; s_poll_id = '0; s_next_desc_rd_id = '0;
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_rdy", 128'(s_rdy), '0);
    chk("reset_err", 128'(err_flags), '0);
    rst = 1'b1;
    tick();
    chk("rdy_after_edge1", 128'(s_rdy), '0);
    tick();
    chk("rdy_after_edge2", 128'(s_rdy), 128'hf);

    for (int i = 1; i <= 8; i++) send_beat(0, 32'(i), 1'b0);
    repeat (3) tick();
    rd(9'h001);
    chk("ch0_word0", s_out_data, 128'h00000004_00000003_00000002_00000001);
    rd(9'h001);
    chk("ch0_word1", s_out_data, 128'h00000008_00000007_00000006_00000005);
    poll(9'h001);
    chk("ch0_seq", 128'(s_poll_seq), 128'h20);

    send_beat(2, 32'hA, 1'b0);
    send_beat(2, 32'hB, 1'b0);
    send_beat(2, 32'hC, 1'b1);
    repeat (3) tick();
    rd(9'h003);
    chk("ch2_partial", s_out_data, 128'h00000000_0000000C_0000000B_0000000A);
    poll(9'h003);
    chk("ch2_seq", 128'(s_poll_seq), 128'h10);

    d0 = {32'h1000_0000, 96'hD0}; d1 = {32'h2000_0000, 96'hD1};
    s_in_valid = 1'b1; s_in_id = 9'h102; s_in_data = d0;
    tick();
    s_in_data = d1;
    tick();
    s_in_valid = 1'b0;
    poll(9'h002);
    chk("desc_head_d0", s_poll_next_desc, d0);
    chk("desc_valid", 128'(s_poll_next_desc_valid), 128'(1));
    s_next_desc_rd_en = 1'b1; s_next_desc_rd_id = 9'h002;
    tick();
    s_next_desc_rd_en = 1'b0;
    poll(9'h002);
    chk("desc_head_d1", s_poll_next_desc, d1);
    poll(9'h102);
    chk("desc_seq", 128'(s_poll_seq), 128'h210);

    rd(9'h003);
    chk("empty_read_data", s_out_data, '0);
    chk("empty_read_err", 128'(err_flags), 128'(3'b001));

    s_in_id = 9'h104;
    for (int i = 0; i < 33; i++) begin
      s_in_valid = 1'b1;
      s_in_data = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) first_desc = s_in_data;
      tick();
    end
    s_in_valid = 1'b0;
    chk("desc_overflow_err", 128'(err_flags), 128'(3'b011));
    poll(9'h004);
    chk("desc_full_head", s_poll_next_desc, first_desc);
    s_next_desc_rd_en = 1'b1; s_next_desc_rd_id = 9'h004;
    repeat (32) tick();
    s_next_desc_rd_en = 1'b0;
    tick();
    chk("desc_drained", 128'(s_poll_next_desc_valid), '0);

    cyc = 0;
    while (cyc < 3000) begin
      s_valid[1] = 1'b1;
      s_data[63:32] = $urandom;
      tick();
      cyc++;
      if (!s_rdy[1]) break;
    end
    s_valid[1] = 1'b0;
    repeat (4) tick();
    chk("fill_rdy_low", 128'(s_rdy[1]), '0);
    chk("fill_words", 128'(m_fifo[1].size() + int'(m_pend_v[1])), 128'(504));
    rd(9'h002);
    chk("rdy_after_pop_edge", 128'(s_rdy[1]), '0);
    tick();
    chk("rdy_rises", 128'(s_rdy[1]), 128'(1));
    send_beat(1, 32'hF1F1, 1'b1);
    repeat (3) tick();
    s_out_en = 1'b1; s_out_id = 9'h002;
    repeat (504) tick();
    s_out_en = 1'b0;
    rd(9'h002);
    chk("fill_drain_empty", s_out_data, '0);

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        s_valid[c] = ($urandom_range(0, 1) == 1);
        s_last[c]  = ($urandom_range(0, 3) == 0);
      end
      s_data            = {$urandom, $urandom, $urandom, $urandom};
      s_out_en          = ($urandom_range(0, 2) == 0);
      s_out_id          = ids[$urandom_range(0, 7)];
      s_in_valid        = ($urandom_range(0, 2) == 0);
      s_in_id           = {2'b10, ids[$urandom_range(0, 7)][6:0]};
      s_in_data         = {$urandom, $urandom, $urandom, $urandom};
      s_next_desc_rd_en = ($urandom_range(0, 2) == 0);
      s_next_desc_rd_id = ids[$urandom_range(0, 7)];
      s_poll_id         = ids[$urandom_range(0, 7)];
      tick();
    end
    idle();
    repeat (3) tick();

    s_poll_id = 9'h001;
    send_beat(0, 32'h77, 1'b0);
    send_beat(0, 32'h78, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out", s_out_data, '0);
    chk("midrst_poll_seq", 128'(s_poll_seq), '0);
    chk("midrst_rdy", 128'(s_rdy), '0);
    chk("midrst_err", 128'(err_flags), '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_seq", 128'(s_poll_seq), '0);
    for (int i = 0; i < 4; i++) send_beat(0, 32'h11 + 32'(i), 1'b0);
    repeat (3) tick();
    rd(9'h001);
    chk("post_rst_word", s_out_data, 128'h00000014_00000013_00000012_00000011);
    tick();
    chk("post_rst_seq2", 128'(s_poll_seq), 128'h10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
